// File: rtl/core2wb_pkg.sv
// Shared types, defaults and helpers for the Ibex-to-Wishbone master bridge.
package core2wb_pkg;

  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_DW = 32;

  // Width needed to count 0..max_out inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage : core2wb_pkg

// File: rtl/core2wb_if.sv
// Bundles for the two sides of the bridge: the Ibex core memory port and the
// pipelined Wishbone B4 master port.
interface core_if
  import core2wb_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
);
  logic              core_req;
  logic              core_gnt;
  logic              core_we;
  logic [AW-1:0]     core_addr;
  logic [DW/8-1:0]   core_be;
  logic [DW-1:0]     core_wdata;
  logic              core_rvalid;
  logic [DW-1:0]     core_rdata;
  logic              core_err;

  // Bridge side: accepts requests, returns responses.
  modport slave (
    input  core_req, core_we, core_addr, core_be, core_wdata,
    output core_gnt, core_rvalid, core_rdata, core_err
  );

  // Core side: issues requests, consumes responses.
  modport master (
    output core_req, core_we, core_addr, core_be, core_wdata,
    input  core_gnt, core_rvalid, core_rdata, core_err
  );
endinterface : core_if

interface wb_if
  import core2wb_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
);
  logic              wb_cyc;
  logic              wb_stb;
  logic              wb_we;
  logic [AW-1:0]     wb_adr;
  logic [DW/8-1:0]   wb_sel;
  logic [DW-1:0]     wb_dat_o;
  logic              wb_stall;
  logic              wb_ack;
  logic              wb_err;
  logic [DW-1:0]     wb_dat_i;
  logic              wb_proto_err;

  // Bridge side: drives the bus cycle.
  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_o, wb_proto_err,
    input  wb_stall, wb_ack, wb_err, wb_dat_i
  );

  // Interconnect side.
  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_o, wb_proto_err,
    output wb_stall, wb_ack, wb_err, wb_dat_i
  );
endinterface : wb_if

// File: rtl/wb_outstanding_cnt.sv
// Saturating up/down counter of issued-but-unanswered Wishbone transfers.
module wb_outstanding_cnt
  import core2wb_pkg::*;
#(
  parameter int unsigned MAX = 2,
  parameter int unsigned CW  = cnt_width(MAX)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  assign full_o  = (cnt_q == MAX_C);
  assign empty_o = (cnt_q == '0);

  // Next count: simultaneous inc and dec cancel; never wraps past 0 or MAX.
  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (inc_i && !dec_i && !full_o) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && !empty_o) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register; reset drops all in-flight bookkeeping at once.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks avoid evaluation-order races.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : wb_outstanding_cnt

// File: rtl/core2wb.sv
// Ibex req/gnt/rvalid/err memory port to pipelined Wishbone B4 master.
// Requests go straight onto the bus with zero added latency; CYC is held
// until every issued transfer has been answered. Responses can optionally
// be registered for timing.
module core2wb
  import core2wb_pkg::*;
#(
  parameter int unsigned DW              = DEF_DW,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          REG_RSP         = 1'b1
) (
  input  logic  clk,
  input  logic  rst_n,
  core_if.slave core,
  wb_if.master  wb
);

  logic cnt_full;
  logic cnt_empty;
  logic stb;
  logic issue;
  logic rsp;
  logic stray;
  logic perr_q, perr_d;

  // Strobe never looks at stall, so a stalled slave still sees a stable
  // request. Reset forces it low at once even while the core keeps asking.
  assign stb   = core.core_req & ~cnt_full & rst_n;
  assign issue = stb & ~wb.wb_stall;

  // A response only counts when something is actually outstanding; an
  // ack and err in the same cycle is a single (error) response.
  assign rsp   = wb.wb_cyc & (wb.wb_ack | wb.wb_err) & ~cnt_empty;
  assign stray = (wb.wb_ack | wb.wb_err) & cnt_empty;

  wb_outstanding_cnt #(
    .MAX (MAX_OUTSTANDING)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (issue),
    .dec_i   (rsp),
    .full_o  (cnt_full),
    .empty_o (cnt_empty)
  );

  assign core.core_gnt = issue;

  assign wb.wb_stb   = stb;
  assign wb.wb_cyc   = stb | ~cnt_empty;
  assign wb.wb_we    = core.core_we;
  assign wb.wb_adr   = core.core_addr;
  assign wb.wb_sel   = core.core_be;
  assign wb.wb_dat_o = core.core_wdata;

  assign perr_d          = perr_q | stray;
  assign wb.wb_proto_err = perr_q;

  // Sticky protocol-error flag: only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  if (REG_RSP) begin : g_rsp_reg
    logic          rvalid_q;
    logic          err_q;
    logic [DW-1:0] rdata_q;

    // Response pipeline stage; rdata only loads on an accepted response.
    always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: rdata is a single register, not a memory, so it is reset to keep the output at 0 in reset.
      if (!rst_n) begin
        rvalid_q <= 1'b0;
        err_q    <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= rsp;
        err_q    <= rsp & wb.wb_err;
        if (rsp) begin
          rdata_q <= wb.wb_dat_i;
        end
      end
    end

    assign core.core_rvalid = rvalid_q;
    assign core.core_err    = err_q;
    assign core.core_rdata  = rdata_q;
  end else begin : g_rsp_comb
    assign core.core_rvalid = rsp;
    assign core.core_err    = wb.wb_err;
    assign core.core_rdata  = wb.wb_dat_i;
  end

endmodule : core2wb

// File: tb/tb_core2wb.sv
// Self-checking bench for core2wb (MAX_OUTSTANDING=2, REG_RSP=1): a directed
// vector table for the main scenarios, hand-written reset sequences, then a
// random phase checked against a queue-based model of outstanding transfers.
module tb_core2wb;

  localparam int MAX = 2;
  localparam bit T = 1'b1;
  localparam bit F = 1'b0;

  logic clk;
  logic rst_n;

  core_if #(.AW(32), .DW(32)) cif ();
  wb_if   #(.AW(32), .DW(32)) wif ();

  core2wb #(
    .DW              (32),
    .MAX_OUTSTANDING (MAX),
    .REG_RSP         (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .core  (cif),
    .wb    (wif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model: queue of outstanding transfers
  logic [31:0] mq[$];
  bit          m_rv;
  bit          m_err;
  bit          m_perr;
  logic [31:0] m_rdata;

  task automatic model_reset();
    mq.delete();
    m_rv    = 1'b0;
    m_err   = 1'b0;
    m_perr  = 1'b0;
    m_rdata = '0;
  endtask

  // One clock cycle: drive inputs (caller sits just after a posedge), check
  // at the falling edge against the model, advance the model, step on.
  task automatic cycle_model(input bit req, input bit we, input bit stall,
                             input bit ack, input bit err,
                             input logic [31:0] dat, input logic [31:0] addr,
                             output bit granted);
    bit e_stb, e_gnt, e_cyc, rsp, stray;
    cif.core_req   = req;
    cif.core_we    = we;
    cif.core_addr  = addr;
    cif.core_be    = 4'hF;
    cif.core_wdata = ~addr;
    wif.wb_stall   = stall;
    wif.wb_ack     = ack;
    wif.wb_err     = err;
    wif.wb_dat_i   = dat;
    e_stb = req && (mq.size() < MAX);
    e_gnt = e_stb && !stall;
    e_cyc = e_stb || (mq.size() > 0);
    rsp   = (ack || err) && (mq.size() > 0);
    stray = (ack || err) && (mq.size() == 0);
    @(negedge clk);
    check1("stb", wif.wb_stb, e_stb);
    check1("gnt", cif.core_gnt, e_gnt);
    check1("cyc", wif.wb_cyc, e_cyc);
    check1("rvalid", cif.core_rvalid, m_rv);
    check1("core_err", cif.core_err, m_err);
    if (m_rv) check32("rdata", cif.core_rdata, m_rdata);
    check1("proto_err", wif.wb_proto_err, m_perr);
    check32("adr", wif.wb_adr, addr);
    check32("dat_o", wif.wb_dat_o, ~addr);
    check1("we", wif.wb_we, we);
    m_rv  = rsp;
    m_err = rsp && err;
    if (rsp) begin
      m_rdata = dat;
      void'(mq.pop_front());
    end
    if (stray) m_perr = 1'b1;
    if (e_gnt) mq.push_back(addr);
    granted = e_gnt;
    @(posedge clk);
    #1;
  endtask

  // Reset with all outputs checked low while asserted; caller sits after a posedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check1("rst_cyc", wif.wb_cyc, 1'b0);
    check1("rst_stb", wif.wb_stb, 1'b0);
    check1("rst_gnt", cif.core_gnt, 1'b0);
    check1("rst_rvalid", cif.core_rvalid, 1'b0);
    check1("rst_err", cif.core_err, 1'b0);
    check1("rst_perr", wif.wb_proto_err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table
  typedef struct {
    bit          req, we, stall, ack, err;
    logic [31:0] dat;
    bit          e_stb, e_gnt, e_cyc, e_rv, e_err;
    logic [31:0] e_rdata;
    bit          e_perr;
  } vec_t;

  vec_t tbl[26];

  initial begin
    bit g;
    bit pend;
    bit w;
    logic [31:0] a;

    rst_n          = 1'b0;
    cif.core_req   = 1'b0;
    cif.core_we    = 1'b0;
    cif.core_addr  = '0;
    cif.core_be    = '0;
    cif.core_wdata = '0;
    wif.wb_stall   = 1'b0;
    wif.wb_ack     = 1'b0;
    wif.wb_err     = 1'b0;
    wif.wb_dat_i   = '0;

    // req we st ack err dat        | stb gnt cyc rv err rdata        perr
    // single read, ack one cycle after stb
    tbl[0]  = '{T,F,F,F,F,32'h0,        T,T,T,F,F,32'h0,        F};
    tbl[1]  = '{F,F,F,T,F,32'hDEADBEEF, F,F,T,F,F,32'h0,        F};
    tbl[2]  = '{F,F,F,F,F,32'h0,        F,F,F,T,F,32'hDEADBEEF, F};
    // request stalled three cycles, granted on the fourth
    tbl[3]  = '{T,F,T,F,F,32'h0,        T,F,T,F,F,32'h0,        F};
    tbl[4]  = '{T,F,T,F,F,32'h0,        T,F,T,F,F,32'h0,        F};
    tbl[5]  = '{T,F,T,F,F,32'h0,        T,F,T,F,F,32'h0,        F};
    tbl[6]  = '{T,F,F,F,F,32'h0,        T,T,T,F,F,32'h0,        F};
    tbl[7]  = '{F,F,F,T,F,32'h12345678, F,F,T,F,F,32'h0,        F};
    tbl[8]  = '{F,F,F,F,F,32'h0,        F,F,F,T,F,32'h12345678, F};
    // fill to MAX, third request waits, granted the cycle after the first ack
    tbl[9]  = '{T,F,F,F,F,32'h0,        T,T,T,F,F,32'h0,        F};
    tbl[10] = '{T,F,F,F,F,32'h0,        T,T,T,F,F,32'h0,        F};
    tbl[11] = '{T,F,F,F,F,32'h0,        F,F,T,F,F,32'h0,        F};
    tbl[12] = '{T,F,F,T,F,32'hA1A1A1A1, F,F,T,F,F,32'h0,        F};
    tbl[13] = '{T,F,F,F,F,32'h0,        T,T,T,T,F,32'hA1A1A1A1, F};
    tbl[14] = '{F,F,F,T,F,32'hA2A2A2A2, F,F,T,F,F,32'h0,        F};
    tbl[15] = '{F,F,F,T,F,32'hA3A3A3A3, F,F,T,T,F,32'hA2A2A2A2, F};
    tbl[16] = '{F,F,F,F,F,32'h0,        F,F,F,T,F,32'hA3A3A3A3, F};
    // write terminated by error
    tbl[17] = '{T,T,F,F,F,32'h0,        T,T,T,F,F,32'h0,        F};
    tbl[18] = '{F,T,F,F,T,32'h0,        F,F,T,F,F,32'h0,        F};
    tbl[19] = '{F,F,F,F,F,32'h0,        F,F,F,T,T,32'h0,        F};
    // ack and err together: one response, flagged as error
    tbl[20] = '{T,F,F,F,F,32'h0,        T,T,T,F,F,32'h0,        F};
    tbl[21] = '{F,F,F,T,T,32'h55,       F,F,T,F,F,32'h0,        F};
    tbl[22] = '{F,F,F,F,F,32'h0,        F,F,F,T,T,32'h55,       F};
    // stray ack while idle: no response, sticky protocol error
    tbl[23] = '{F,F,F,T,F,32'h0,        F,F,F,F,F,32'h0,        F};
    tbl[24] = '{F,F,F,F,F,32'h0,        F,F,F,F,F,32'h0,        T};
    tbl[25] = '{F,F,F,F,F,32'h0,        F,F,F,F,F,32'h0,        T};

    #1;
    do_reset();

    for (int i = 0; i < 26; i++) begin
      cif.core_req   = tbl[i].req;
      cif.core_we    = tbl[i].we;
      cif.core_addr  = 32'h1000 + 32'(i);
      cif.core_be    = 4'hF;
      cif.core_wdata = 32'hC0DE0000 + 32'(i);
      wif.wb_stall   = tbl[i].stall;
      wif.wb_ack     = tbl[i].ack;
      wif.wb_err     = tbl[i].err;
      wif.wb_dat_i   = tbl[i].dat;
      @(negedge clk);
      check1($sformatf("v%0d_stb", i), wif.wb_stb, tbl[i].e_stb);
      check1($sformatf("v%0d_gnt", i), cif.core_gnt, tbl[i].e_gnt);
      check1($sformatf("v%0d_cyc", i), wif.wb_cyc, tbl[i].e_cyc);
      check1($sformatf("v%0d_rvalid", i), cif.core_rvalid, tbl[i].e_rv);
      check1($sformatf("v%0d_err", i), cif.core_err, tbl[i].e_err);
      if (tbl[i].e_rv) check32($sformatf("v%0d_rdata", i), cif.core_rdata, tbl[i].e_rdata);
      check1($sformatf("v%0d_perr", i), wif.wb_proto_err, tbl[i].e_perr);
      check32($sformatf("v%0d_adr", i), wif.wb_adr, 32'h1000 + 32'(i));
      check1($sformatf("v%0d_we", i), wif.wb_we, tbl[i].we);
      @(posedge clk);
      #1;
    end

    // ---------------- reset with two transfers outstanding
    do_reset();
    cycle_model(T, F, F, F, F, 32'h0, 32'h100, g);
    cycle_model(T, F, F, F, F, 32'h0, 32'h104, g);
    cif.core_req = 1'b1;
    #1;
    check1("full_cyc", wif.wb_cyc, 1'b1);
    check1("full_stb", wif.wb_stb, 1'b0);
    rst_n = 1'b0;
    #1;
    check1("async_cyc", wif.wb_cyc, 1'b0);
    check1("async_stb", wif.wb_stb, 1'b0);
    check1("async_gnt", cif.core_gnt, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cycle_model(F, F, F, F, F, 32'h0, 32'h0, g);

    // reset while a registered response is being presented
    cycle_model(T, F, F, F, F, 32'h0, 32'h200, g);
    cycle_model(F, F, F, T, F, 32'h77, 32'h0, g);
    #1;
    check1("pre_rst_rvalid", cif.core_rvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("async_rvalid", cif.core_rvalid, 1'b0);
    check32("async_rdata", cif.core_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    // late ack from a transfer that reset discarded
    cycle_model(F, F, F, T, F, 32'h0, 32'h0, g);
    cycle_model(F, F, F, F, F, 32'h0, 32'h0, g);
    cycle_model(F, F, F, F, F, 32'h0, 32'h0, g);

    // ---------------- random traffic against the model
    do_reset();
    pend = 1'b0;
    w    = 1'b0;
    a    = '0;
    for (int i = 0; i < 600; i++) begin
      bit st, ak, er;
      if (!pend) begin
        pend = ($urandom_range(0, 9) < 7);
        a    = $urandom;
        w    = 1'($urandom_range(0, 1));
      end
      st = ($urandom_range(0, 9) < 3);
      if (mq.size() > 0) begin
        ak = ($urandom_range(0, 9) < 5);
        er = ($urandom_range(0, 9) < 1);
      end else begin
        ak = ($urandom_range(0, 99) < 2);
        er = 1'b0;
      end
      cycle_model(pend, w, st, ak, er, $urandom, a, g);
      if (g) pend = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_core2wb
